// File: rtl/ymem_read_arbiter_pkg.sv
// Shared types and constants for the Y-matrix memory read arbiter.
// The optional fixed-priority build is selected with YMEM_ARB_FIXED_PRIO_EN (see ymem_read_arbiter).
package ymem_arb_pkg;

  localparam int YMEM_ADDR_W = 11;
  localparam int YMEM_DATA_W = 256;
  localparam logic [YMEM_ADDR_W-1:0] YMEM_ADDR_IDLE = '1;

  typedef logic req_id_t;

  // Travels alongside each issued read until its data returns.
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    port2_real;
  } rd_tag_t;

  typedef struct packed {
    req_id_t last;
    logic    lockActive;
    req_id_t lockId;
  } arb_state_t;

endpackage

// File: rtl/ymem_read_arbiter_if.sv
// Requester and memory-side signals of the Y-matrix read arbiter.
// Handshake: reqN and its address pair stay stable until gntN is seen high; reqN && gntN in
// one cycle is an accepted read. Return data has no back-pressure and is valid only while rvalidN is high.
interface ymem_read_arbiter_if
  import ymem_arb_pkg::*;
#(
  parameter int ADDR_W = YMEM_ADDR_W,
  parameter int DATA_W = YMEM_DATA_W
);
  logic              req0, req1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr1_0, addr2_0, addr1_1, addr2_1;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] mem_addr1, mem_addr2;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_rdata1, mem_rdata2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              rvalid0, rvalid1, rvalid2;

  modport slave (
    input  req0, req1, lock0, lock1, addr1_0, addr2_0, addr1_1, addr2_1,
    input  mem_rdata1, mem_rdata2,
    output gnt0, gnt1, mem_addr1, mem_addr2, mem_rden,
    output rdata1, rdata2, rvalid0, rvalid1, rvalid2
  );

  modport master (
    output req0, req1, lock0, lock1, addr1_0, addr2_0, addr1_1, addr2_1,
    output mem_rdata1, mem_rdata2,
    input  gnt0, gnt1, mem_addr1, mem_addr2, mem_rden,
    input  rdata1, rdata2, rvalid0, rvalid1, rvalid2
  );
endinterface

// File: rtl/ymem_read_arbiter_tag_pipe.sv
// Read-tag delay line matching the memory read latency; a synchronous clear drops
// every in-flight tag so reads issued before reset never report return data.
module ymem_arb_tag_pipe
  import ymem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t tagIn,
  output rd_tag_t tagOut
);
  rd_tag_t stages [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tagIn;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tagOut = stages[DEPTH-1];
endmodule

// File: rtl/ymem_read_arbiter.sv
// Shares the Y-memory read ports between the row-address generator (0) and the X/column fetch (1).
// Round-robin with burst lock; define YMEM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module ymem_read_arbiter
  import ymem_arb_pkg::*;
#(
  parameter int ADDR_W = YMEM_ADDR_W,
  parameter int DATA_W = YMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  ymem_read_arbiter_if.slave bus,
  output arb_state_t         dbgState
);
`ifdef YMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] ADDR_IDLE = {ADDR_W{1'b1}};

  arb_state_t        state, stateNext;
  logic [1:0]        req;
  logic              accept;
  req_id_t           winner;
  logic [ADDR_W-1:0] winAddr1, winAddr2;
  rd_tag_t           issuedTag, retTag;

  assign req = {bus.req1, bus.req0};

  always_ff @(posedge clock) begin : stateReg
    if (!reset) state <= '{last: 1'b1, lockActive: 1'b0, lockId: 1'b0};
    else        state <= stateNext;
  end

  // Only the current grantee can hold a lock, so a lock never competes with another lock.
  always_comb begin : nextState
    accept = reset && (|req);
    winner = 1'b0;
    if (state.lockActive && req[state.lockId]) winner = state.lockId;
    else if (&req)                             winner = FIXED_PRIO ? 1'b0 : !state.last;
    else                                       winner = bus.req1;

    stateNext            = state;
    stateNext.lockActive = 1'b0;
    if (accept) begin
      stateNext.last       = winner;
      stateNext.lockId     = winner;
      stateNext.lockActive = winner ? (bus.lock1 && !FIXED_PRIO) : bus.lock0;
    end
  end

  always_comb begin : outputs
    bus.gnt0 = accept && (winner == 1'b0);
    bus.gnt1 = accept && (winner == 1'b1);
    dbgState = state;
  end

  assign winAddr1 = winner ? bus.addr1_1 : bus.addr1_0;
  assign winAddr2 = winner ? bus.addr2_1 : bus.addr2_0;

  always_ff @(posedge clock) begin : addrReg
    if (!reset || !accept) begin
      bus.mem_addr1 <= ADDR_IDLE;
      bus.mem_addr2 <= ADDR_IDLE;
      bus.mem_rden  <= 1'b0;
      issuedTag     <= '0;
    end else begin
      bus.mem_addr1 <= winAddr1;
      bus.mem_addr2 <= winAddr2;
      bus.mem_rden  <= 1'b1;
      issuedTag     <= '{valid: 1'b1, id: winner, port2_real: (winAddr2 != ADDR_IDLE)};
    end
  end

  // The tag leaves the address register with the read, so it emerges with the data RD_LAT later.
  ymem_arb_tag_pipe #(.DEPTH(RD_LAT)) u_tagPipe (
    .clock  (clock),
    .reset  (reset),
    .tagIn  (issuedTag),
    .tagOut (retTag)
  );

  assign bus.rvalid0 = retTag.valid && (retTag.id == 1'b0);
  assign bus.rvalid1 = retTag.valid && (retTag.id == 1'b1);
  assign bus.rvalid2 = retTag.valid && retTag.port2_real;
  assign bus.rdata1  = DATA_W'(bus.mem_rdata1);
  assign bus.rdata2  = DATA_W'(bus.mem_rdata2);
endmodule

// File: tb/tb_ymem_read_arbiter.sv
// Directed bench for ymem_read_arbiter: cycle table for arbitration/lock/return tags,
// plus hand sequences for reset behaviour and RD_LAT=2 flush.
module tb_ymem_read_arbiter;
  import ymem_arb_pkg::*;

  localparam logic [10:0] I = 11'h7FF;

  logic       clock = 1'b0;
  logic       reset, reset2;
  arb_state_t dbgState, dbgState2;
  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  ymem_read_arbiter_if #(.ADDR_W(11), .DATA_W(256)) bus ();
  ymem_read_arbiter_if #(.ADDR_W(11), .DATA_W(256)) bus2 ();

  ymem_read_arbiter #(.ADDR_W(11), .DATA_W(256), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset), .bus(bus), .dbgState(dbgState)
  );
  ymem_read_arbiter #(.ADDR_W(11), .DATA_W(256), .RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset2), .bus(bus2), .dbgState(dbgState2)
  );

  always #5 clock = ~clock;

  // in = {req0, req1, lock0, lock1}; gnt = {gnt0, gnt1}; out = {mem_rden, rvalid0, rvalid1, rvalid2}
  typedef struct {
    logic [3:0]  in;
    logic [10:0] a10, a20, a11, a21;
    logic [1:0]  gnt;
    logic [10:0] m1, m2;
    logic [3:0]  out;
  } vec_t;

  vec_t tbl [21];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_addr(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;  bus.req1 = 1'b0;  bus.lock0 = 1'b0;  bus.lock1 = 1'b0;
    bus.addr1_0 = I;  bus.addr2_0 = I;  bus.addr1_1 = I;  bus.addr2_1 = I;
    bus.mem_rdata1 = '0;  bus.mem_rdata2 = '0;
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.lock0 = 1'b0; bus2.lock1 = 1'b0;
    bus2.addr1_0 = I; bus2.addr2_0 = I; bus2.addr1_1 = I; bus2.addr2_1 = I;
    bus2.mem_rdata1 = '0; bus2.mem_rdata2 = '0;
  endtask

  task automatic drive(input vec_t v);
    {bus.req0, bus.req1, bus.lock0, bus.lock1} = v.in;
    bus.addr1_0 = v.a10; bus.addr2_0 = v.a20;
    bus.addr1_1 = v.a11; bus.addr2_1 = v.a21;
  endtask

  task automatic check_row(input int k, input vec_t v);
    chk_bit($sformatf("row%0d gnt0", k), bus.gnt0, v.gnt[1]);
    chk_bit($sformatf("row%0d gnt1", k), bus.gnt1, v.gnt[0]);
    chk_addr($sformatf("row%0d mem_addr1", k), bus.mem_addr1, v.m1);
    chk_addr($sformatf("row%0d mem_addr2", k), bus.mem_addr2, v.m2);
    chk_bit($sformatf("row%0d mem_rden", k), bus.mem_rden, v.out[3]);
    chk_bit($sformatf("row%0d rvalid0", k), bus.rvalid0, v.out[2]);
    chk_bit($sformatf("row%0d rvalid1", k), bus.rvalid1, v.out[1]);
    chk_bit($sformatf("row%0d rvalid2", k), bus.rvalid2, v.out[0]);
  endtask

  initial begin
    reset  = 1'b0;
    reset2 = 1'b0;
    idle_inputs();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr1_0 = 11'h011; bus.addr1_1 = 11'h022;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_bit("reset gnt0", bus.gnt0, 1'b0);
    chk_bit("reset gnt1", bus.gnt1, 1'b0);
    chk_addr("reset mem_addr1", bus.mem_addr1, I);
    chk_addr("reset mem_addr2", bus.mem_addr2, I);
    chk_bit("reset mem_rden", bus.mem_rden, 1'b0);
    chk_bit("reset rvalid0", bus.rvalid0, 1'b0);
    chk_bit("reset rvalid1", bus.rvalid1, 1'b0);
    chk_bit("reset rvalid2", bus.rvalid2, 1'b0);
    chk_bit("reset last", dbgState.last, 1'b1);
    chk_bit("reset lockActive", dbgState.lockActive, 1'b0);
    @(posedge clock); #1;
    reset  = 1'b1;
    reset2 = 1'b1;
    idle_inputs();

`ifndef YMEM_ARB_FIXED_PRIO_EN
    tbl[0]  = '{4'b1100, 11'h010, I,      11'h020, 11'h021, 2'b10, I,       I,       4'b0000};
    tbl[1]  = '{4'b1100, 11'h030, 11'h031, 11'h020, 11'h021, 2'b01, 11'h010, I,       4'b1000};
    tbl[2]  = '{4'b1100, 11'h030, 11'h031, 11'h040, I,      2'b10, 11'h020, 11'h021, 4'b1100};
    tbl[3]  = '{4'b1100, 11'h050, 11'h051, 11'h040, I,      2'b01, 11'h030, 11'h031, 4'b1011};
    tbl[4]  = '{4'b1000, 11'h050, 11'h051, I,       I,      2'b10, 11'h040, I,       4'b1101};
    tbl[5]  = '{4'b0000, I,       I,       I,       I,      2'b00, 11'h050, 11'h051, 4'b1010};
    tbl[6]  = '{4'b0100, I,       I,       I,       11'h060, 2'b01, I,      I,       4'b0101};
    tbl[7]  = '{4'b1110, 11'h070, 11'h071, 11'h080, 11'h081, 2'b10, I,       11'h060, 4'b1000};
    tbl[8]  = '{4'b1110, 11'h072, 11'h073, 11'h080, 11'h081, 2'b10, 11'h070, 11'h071, 4'b1011};
    tbl[9]  = '{4'b1100, 11'h074, 11'h075, 11'h080, 11'h081, 2'b10, 11'h072, 11'h073, 4'b1101};
    tbl[10] = '{4'b1100, 11'h076, 11'h077, 11'h080, 11'h081, 2'b01, 11'h074, 11'h075, 4'b1101};
    tbl[11] = '{4'b1000, 11'h076, 11'h077, I,       I,      2'b10, 11'h080, 11'h081, 4'b1101};
    tbl[12] = '{4'b1010, 11'h090, 11'h091, I,       I,      2'b10, 11'h076, 11'h077, 4'b1011};
    tbl[13] = '{4'b0100, I,       I,       11'h0A0, 11'h0A1, 2'b01, 11'h090, 11'h091, 4'b1101};
    tbl[14] = '{4'b1101, 11'h0B0, 11'h0B1, 11'h0C0, 11'h0C1, 2'b10, 11'h0A0, 11'h0A1, 4'b1101};
    tbl[15] = '{4'b1101, 11'h0B2, 11'h0B3, 11'h0C0, 11'h0C1, 2'b01, 11'h0B0, 11'h0B1, 4'b1011};
    tbl[16] = '{4'b1100, 11'h0B2, 11'h0B3, 11'h0C2, 11'h0C3, 2'b01, 11'h0C0, 11'h0C1, 4'b1101};
    tbl[17] = '{4'b1000, 11'h0B2, 11'h0B3, I,       I,      2'b10, 11'h0C2, 11'h0C3, 4'b1011};
    tbl[18] = '{4'b0000, I,       I,       I,       I,      2'b00, 11'h0B2, 11'h0B3, 4'b1011};
    tbl[19] = '{4'b0000, I,       I,       I,       I,      2'b00, I,       I,       4'b0101};
    tbl[20] = '{4'b0000, I,       I,       I,       I,      2'b00, I,       I,       4'b0000};

    for (int k = 0; k < 21; k++) begin
      drive(tbl[k]);
      bus.mem_rdata1 = {8{32'hA500_0000 + 32'(k)}};
      bus.mem_rdata2 = ~bus.mem_rdata1;
      if (tbl[k].gnt[1]) exp_q.push_back({1'b0, tbl[k].a20 != I});
      if (tbl[k].gnt[0]) exp_q.push_back({1'b1, tbl[k].a21 != I});
      @(negedge clock);
      check_row(k, tbl[k]);
      chk_data($sformatf("row%0d rdata1", k), bus.rdata1, {8{32'hA500_0000 + 32'(k)}});
      chk_data($sformatf("row%0d rdata2", k), bus.rdata2, ~{8{32'hA500_0000 + 32'(k)}});
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_q.size() == 0) begin
          chk_bit($sformatf("row%0d unexpected return", k), 1'b1, 1'b0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk_bit($sformatf("row%0d sb id", k), bus.rvalid1, e[1]);
          chk_bit($sformatf("row%0d sb port2", k), bus.rvalid2, e[0]);
        end
      end
      @(posedge clock); #1;
    end
    chk_bit("scoreboard drained", exp_q.size() == 0, 1'b1);
`else
    for (int k = 0; k < 4; k++) begin
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.addr1_0 = 11'(11'h100 + k); bus.addr2_0 = 11'h101;
      bus.addr1_1 = 11'h200;          bus.addr2_1 = 11'h201;
      @(negedge clock);
      chk_bit($sformatf("fixed%0d gnt0", k), bus.gnt0, 1'b1);
      chk_bit($sformatf("fixed%0d gnt1", k), bus.gnt1, 1'b0);
      if (k > 0) chk_addr($sformatf("fixed%0d mem_addr1", k), bus.mem_addr1, 11'(11'h100 + k - 1));
      @(posedge clock); #1;
    end
`endif
    idle_inputs();

    // RD_LAT=2 instance: reset one cycle after an accept must swallow that read.
    bus2.req0 = 1'b1; bus2.addr1_0 = 11'h100; bus2.addr2_0 = 11'h101;
    @(negedge clock);
    chk_bit("flush accept gnt0", bus2.gnt0, 1'b1);
    @(posedge clock); #1;
    bus2.req0 = 1'b0;
    reset2    = 1'b0;
    @(negedge clock);
    chk_bit("flush issued mem_rden", bus2.mem_rden, 1'b1);
    chk_addr("flush issued mem_addr1", bus2.mem_addr1, 11'h100);
    @(posedge clock); #1;
    reset2 = 1'b1;
    @(negedge clock);
    chk_bit("flush cleared mem_rden", bus2.mem_rden, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk_bit($sformatf("flush c%0d no rvalid", c),
              bus2.rvalid0 || bus2.rvalid1 || bus2.rvalid2, 1'b0);
      @(posedge clock); #1;
      @(negedge clock);
    end

    // Same instance afterwards: a normal read returns RD_LAT+1 cycles after accept.
    @(posedge clock); #1;
    bus2.req0 = 1'b1; bus2.addr1_0 = 11'h110; bus2.addr2_0 = I;
    @(negedge clock);
    chk_bit("lat2 accept gnt0", bus2.gnt0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      bus2.req0 = 1'b0;
      @(negedge clock);
      if (c == 1) chk_addr("lat2 mem_addr1", bus2.mem_addr1, 11'h110);
      chk_bit($sformatf("lat2 c%0d rvalid0", c), bus2.rvalid0, c == 3);
      chk_bit($sformatf("lat2 c%0d rvalid1", c), bus2.rvalid1, 1'b0);
      chk_bit($sformatf("lat2 c%0d rvalid2", c), bus2.rvalid2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
